// File: rtl/debug_bus_poller.sv
// Debug-bus initiator: sends a 3-byte read request to one AXIS debug device, either periodically or on demand.
// It then checks the 2-byte response header and captures a big-endian payload value.
module debug_bus_poller #(
  parameter int         AXIS_TDATA_WIDTH   = 8,
  parameter logic [7:0] DEVICE_TYPE        = 8'h01,
  parameter logic [7:0] DEVICE_ID          = 8'h00,
  parameter logic [7:0] COMMAND            = 8'h00,
  parameter int         RESPONSE_BYTES     = 4,
  parameter int         POLL_PERIOD_CYCLES = 200_000_000,
  parameter int         TIMEOUT_CYCLES     = 1_000_000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_trigger,
  output logic                          o_m_axis_tvalid,
  input  logic                          i_m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]   o_m_axis_tdata,
  output logic                          o_m_axis_tlast,
  input  logic                          i_s_axis_tvalid,
  output logic                          o_s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   i_s_axis_tdata,
  input  logic                          i_s_axis_tlast,
  output logic [8*RESPONSE_BYTES-1:0]   o_value,
  output logic                          o_value_valid,
  output logic                          o_error,
  output logic                          o_busy
);

  localparam int          VW          = 8 * RESPONSE_BYTES;
  localparam logic [3:0]  LAST_K      = 4'(RESPONSE_BYTES + 1);
  localparam logic [31:0] PERIOD_MAX  = 32'(POLL_PERIOD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_MAX = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          POLL_EN     = (POLL_PERIOD_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_RECV  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic [31:0]     period_q, period_d;
  logic [31:0]     timer_q, timer_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      k_q, k_d;
  logic [VW-1:0]   payload_q, payload_d;
  logic            m_tvalid_q, m_tvalid_d;
  logic [7:0]      m_tdata_q, m_tdata_d;
  logic            m_tlast_q, m_tlast_d;
  logic            s_tready_q, s_tready_d;
  logic [VW-1:0]   value_q, value_d;
  logic            value_valid_q, value_valid_d;
  logic            error_q, error_d;
  logic            busy_q, busy_d;

  logic            period_wrap_s;
  logic            m_fire_s;
  logic            s_fire_s;
  logic            s_done_s;
  logic            hdr_bad_s;
  logic            timeout_s;
  logic [VW-1:0]   shift_s;

  // Next-state, period/timeout counters and registered-output computation.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    period_d      = period_q;
    timer_d       = timer_q;
    idx_d         = idx_q;
    k_d           = k_q;
    payload_d     = payload_q;
    m_tvalid_d    = m_tvalid_q;
    m_tdata_d     = m_tdata_q;
    m_tlast_d     = m_tlast_q;
    s_tready_d    = s_tready_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    error_d       = 1'b0;
    period_wrap_s = 1'b0;

    m_fire_s  = m_tvalid_q & i_m_axis_tready;
    s_fire_s  = s_tready_q & i_s_axis_tvalid;
    s_done_s  = s_fire_s & i_s_axis_tlast;
    hdr_bad_s = ((k_q == 4'd0) && (i_s_axis_tdata != DEVICE_TYPE)) ||
                ((k_q == 4'd1) && (i_s_axis_tdata != DEVICE_ID));
    timeout_s = (timer_q == TIMEOUT_MAX);
    // Keeps the low bytes of the running payload; the oldest byte falls off the top.
    shift_s   = VW'({payload_q, i_s_axis_tdata});

    if (POLL_EN) begin
      if (period_q == PERIOD_MAX) begin
        period_d      = 32'd0;
        period_wrap_s = 1'b1;
      end else begin
        period_d = period_q + 32'd1;
      end
    end else begin
      period_d = 32'd0;
    end
    pending_d = pending_q | i_trigger | period_wrap_s;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          // A request arriving in the same cycle is kept rather than lost.
          state_d    = S_SEND;
          pending_d  = i_trigger | period_wrap_s;
          idx_d      = 2'd0;
          m_tvalid_d = 1'b1;
          m_tdata_d  = DEVICE_TYPE;
          m_tlast_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (m_fire_s) begin
          case (idx_q)
            2'd0: begin
              idx_d     = 2'd1;
              m_tdata_d = DEVICE_ID;
            end
            2'd1: begin
              idx_d     = 2'd2;
              m_tdata_d = COMMAND;
              m_tlast_d = 1'b1;
            end
            default: begin
              idx_d      = 2'd0;
              m_tvalid_d = 1'b0;
              m_tdata_d  = 8'h00;
              m_tlast_d  = 1'b0;
              k_d        = 4'd0;
              timer_d    = 32'd0;
              payload_d  = '0;
              s_tready_d = 1'b1;
              state_d    = S_RECV;
            end
          endcase
        end else begin
          state_d = S_SEND;
        end
      end
      S_RECV: begin
        timer_d = timer_q + 32'd1;
        if (s_done_s) begin
          state_d    = S_IDLE;
          s_tready_d = 1'b0;
          if (!hdr_bad_s && (k_q == LAST_K)) begin
            value_d       = shift_s;
            value_valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (timeout_s) begin
          state_d    = S_IDLE;
          s_tready_d = 1'b0;
          error_d    = 1'b1;
        end else if (s_fire_s && (hdr_bad_s || (k_q == LAST_K))) begin
          state_d = S_DRAIN;
        end else if (s_fire_s) begin
          k_d = k_q + 4'd1;
          if (k_q >= 4'd2) begin
            payload_d = shift_s;
          end else begin
            payload_d = payload_q;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_DRAIN: begin
        timer_d = timer_q + 32'd1;
        if (s_done_s || timeout_s) begin
          state_d    = S_IDLE;
          s_tready_d = 1'b0;
          error_d    = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d    = S_IDLE;
        m_tvalid_d = 1'b0;
        m_tlast_d  = 1'b0;
        s_tready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction without an error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      pending_q     <= 1'b0;
      period_q      <= 32'd0;
      timer_q       <= 32'd0;
      idx_q         <= 2'd0;
      k_q           <= 4'd0;
      payload_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= 8'h00;
      m_tlast_q     <= 1'b0;
      s_tready_q    <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      period_q      <= period_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      k_q           <= k_d;
      payload_q     <= payload_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tdata_q     <= m_tdata_d;
      m_tlast_q     <= m_tlast_d;
      s_tready_q    <= s_tready_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end

  assign o_m_axis_tvalid = m_tvalid_q;
  assign o_m_axis_tdata  = m_tdata_q;
  assign o_m_axis_tlast  = m_tlast_q;
  assign o_s_axis_tready = s_tready_q;
  assign o_value         = value_q;
  assign o_value_valid   = value_valid_q;
  assign o_error         = error_q;
  assign o_busy          = busy_q;

endmodule

// File: doc/debug_bus_poller.md
# debug_bus_poller

Debug-bus initiator that issues read-request packets to one AXIS debug device and parses its response packets. It sends requests periodically or on demand, checks the response header, assembles a big-endian value and reports completion or error. It sits between an on-chip debug device's slave/master AXIS ports and local logic such as LEDs or a status register, with no host over UART in the loop.

## Interface
- AXIS_TDATA_WIDTH, 8: beat width; only 8 is supported.
- DEVICE_TYPE, 8'h01: first request byte and expected first response byte.
- DEVICE_ID, 8'h00: second request byte and expected second response byte.
- COMMAND, 8'h00: third and final request byte.
- RESPONSE_BYTES, 4: payload bytes after the 2-byte header; range 1..8.
- POLL_PERIOD_CYCLES, 200_000_000: auto-poll period in cycles; 0 disables auto-poll.
- TIMEOUT_CYCLES, 1_000_000: maximum cycles from last request beat to last response beat.
- Clock/reset (already decided): one clock `i_clk`; reset `i_rst_n` is asynchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_trigger  in  1  single-cycle request for an immediate poll
- o_m_axis_tvalid  out  1  request valid
- i_m_axis_tready  in  1  request ready
- o_m_axis_tdata  out  8  request byte
- o_m_axis_tlast  out  1  last request byte
- i_s_axis_tvalid  in  1  response valid
- o_s_axis_tready  out  1  response ready
- i_s_axis_tdata  in  8  response byte
- i_s_axis_tlast  in  1  last response byte
- o_value  out  8*RESPONSE_BYTES  last good payload, big-endian (first byte is MSB)
- o_value_valid  out  1  1-cycle pulse: o_value updated
- o_error  out  1  1-cycle pulse: transaction failed
- o_busy  out  1  high in any state other than IDLE

## Operation
- Pending flag:
  - Set by i_trigger.
  - Set when the period counter wraps. The counter runs 0..POLL_PERIOD_CYCLES-1 continuously, including while busy.
  - Cleared on the IDLE→SEND transition.
  - Multiple requests while busy collapse into one.
- States: IDLE, SEND, RECV, DRAIN.
- IDLE: o_busy=0, tvalid=0, tready=0. Goes to SEND when the pending flag is set.
- SEND: presents beats DEVICE_TYPE, DEVICE_ID, COMMAND (tlast on beat 3). Each beat advances on tvalid&&tready. After beat 3 is accepted, clears the byte index and timeout counter and goes to RECV.
- RECV: tready=1. Byte index k counts accepted beats.
  - k=0 must equal DEVICE_TYPE; k=1 must equal DEVICE_ID.
  - k=2..RESPONSE_BYTES+1 shift into a payload register (MSB first).
  - tlast at k=RESPONSE_BYTES+1 with header OK: load o_value, pulse o_value_valid, go to IDLE.
  - tlast with k<RESPONSE_BYTES+1, or header mismatch on a beat carrying tlast: pulse o_error, go to IDLE. o_value unchanged.
  - Header mismatch without tlast, or k reaching RESPONSE_BYTES+1 without tlast: go to DRAIN. A later tlast is still required.
- DRAIN: tready=1. Discards beats until tlast, then pulses o_error and goes to IDLE.
- Timeout:
  - Counter increments every cycle in RECV/DRAIN.
  - At TIMEOUT_CYCLES-1 without completion: pulse o_error, go to IDLE.
  - A response arriving after the timeout is accepted by nothing (tready=0 in IDLE) until the next RECV. The next transaction will then see it, fail the header check and drain.
- SEND has no timeout; backpressure is unbounded.

## Timing
- Reset values of all outputs: o_m_axis_tvalid=0, o_m_axis_tlast=0, o_m_axis_tdata=0, o_s_axis_tready=0, o_value=0, o_value_valid=0, o_error=0, o_busy=0. Reset also clears the pending flag and all counters.
- A reset mid-transaction aborts immediately; no error pulse.
- i_trigger high in cycle N: tvalid high in cycle N+2 (one cycle to set pending, one to leave IDLE).
- Request outputs are registered. tdata/tlast stay stable while tvalid && !tready.
- o_value/o_value_valid: registered, asserted in the cycle after the final response beat is accepted.
- o_error: 1-cycle pulse in the cycle after the failing beat, or after timeout expiry.
- o_value_valid and o_error are never high together.
- Back-to-back operation: if pending is set on the return to IDLE, SEND starts the next cycle. Minimum gap is one IDLE cycle.
- i_trigger in the same cycle as a period wrap sets pending once.

## Test plan
- Reset, i_trigger, tready=1 → beats 01,00,00 on cycles 2–4 with tlast on beat 3. Reply 01,00,DE,AD,BE,EF(tlast) → o_value=32'hDEADBEEF, o_value_valid pulse, o_error=0.
- Random tready/tvalid throttling on both sides → same bytes and result. Request data stays stable while stalled.
- Reply 02,00,11,22,33,44(tlast) → DRAIN, then o_error pulse after tlast. o_value stays DEADBEEF.
- Short reply 01,00,11(tlast) → o_error. Long reply of 7 bytes → DRAIN; o_error after the 7th byte.
- No reply, TIMEOUT_CYCLES=100 → o_error exactly 100 cycles after the 3rd request beat is accepted. o_busy falls with it.
- POLL_PERIOD_CYCLES=50, responder always answers, i_trigger pulsed while busy → exactly one extra poll. Deassert i_rst_n mid-RECV → all outputs 0 at once, no o_error.
